read_write_logic: RTL and testbench
===================================

# read_write_logic

Bus-side read/write control for the 8259-compatible PIC. Samples the active-low chip select, read and write strobes from the CPU bus, generates a qualified read enable for the data-bus output driver and a single-cycle write strobe at the trailing edge of each valid write. On each write strobe it decodes the command-word class (ICW1 / OCW2 / OCW3 / A0=1 word) for the control logic and register file.

## Interface
- No parameters.
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- chip_select  input  1  CS#, active low
- read_flag  input  1  RD#, active low
- write_flag  input  1  WR#, active low
- a0  input  1  address bit A0
- data_in  input  8  CPU data bus, write direction
- read_enable  output  1  high while a qualified read is in progress
- read_a0  output  1  A0 captured during current/last read (register select for readback)
- write_enable  output  1  one-cycle pulse at end of a qualified write
- write_data  output  8  data latched during the write; valid while write_enable=1 and held until next write
- icw1_write  output  1  pulse: write with A0=0, D4=1
- ocw2_write  output  1  pulse: write with A0=0, D4=0, D3=0
- ocw3_write  output  1  pulse: write with A0=0, D4=0, D3=1
- a0_high_write  output  1  pulse: write with A0=1 (ICW2/3/4 or OCW1; sequencing is the control block's job)

## Operation
- Input stage: chip_select, read_flag, write_flag, a0, data_in registered each clk (cs_q, rd_q, wr_q, a0_q, d_q). All decisions use sampled values only.
- Read: read_enable = registered (cs_q==0 && rd_q==0 && wr_q==1). read_a0 loads a0_q on every cycle where that condition holds; otherwise holds.
- Write tracking: internal flag write_active set when cs_q==0 && wr_q==0. While set, write_data and internal A0 latch update each cycle from d_q / a0_q (last value before trailing edge wins).
- Write completion: when write_active and wr_q returns to 1 with cs_q still 0, assert write_enable and exactly one decode pulse for one cycle, clear write_active.
- Abort: if cs_q goes 1 while write_active, clear write_active, no strobe, write_data unchanged.
- Decode (from latched A0/data): A0=1 -> a0_high_write; A0=0 & D4=1 -> icw1_write; A0=0 & D4=0 & D3=0 -> ocw2_write; A0=0 & D4=0 & D3=1 -> ocw3_write. Decode pulses coincide with write_enable; never asserted otherwise.
- CS high: read_enable 0, no write started, regardless of RD#/WR#.
- RD# and WR# both low with CS low: write has priority; read_enable forced 0; write proceeds normally.
- Read between two writes: each write produces its own strobe; read_enable only during the RD# low window.

## Timing
- Reset (synchronous, clk edge with reset=1): read_enable, write_enable, all decode pulses = 0; write_data = 8'h00; read_a0 = 0; cs_q/rd_q/wr_q = 1 (inactive), write_active = 0. No spurious strobe on reset release.
- read_enable: asserts 2 clk edges after RD# falls (input register + output register), deasserts 2 edges after RD# rises or CS# rises.
- write_enable: asserted in the cycle after the edge that samples WR# high; width exactly 1 clk per write, independent of WR# low width (minimum WR# low = 1 clk).
- Reset mid-write: write_active cleared, no strobe generated on subsequent WR# rise.
- Back-to-back writes separated by ≥1 clk of WR# high each yield separate pulses.

## Test plan
- Read, CS#=0: RD# low 3 clk -> read_enable=1 for 3 clk, starting 2 edges after fall; write_enable stays 0.
- Two writes, CS#=0: WR# low 1 clk with A0=0, data=8'h13, then WR# low with A0=1, data=8'h20 -> write_enable pulses twice (1 clk each); first with icw1_write=1, write_data=8'h13; second with a0_high_write=1, write_data=8'h20.
- OCW decode: A0=0 data=8'h20 -> ocw2_write only; A0=0 data=8'h0B -> ocw3_write only.
- CS#=1: RD# and WR# toggled -> read_enable=0, write_enable=0, write_data unchanged.
- Simultaneous RD#/WR# low with CS#=0 -> read_enable=0 throughout; one write_enable pulse on WR# rise. Then write, read, write sequence -> two write pulses, read_enable only in read window.
- Reset asserted while WR# low, then WR# rises after reset release -> no write_enable; all outputs 0.

Source files
------------

// File: rtl/read_write_logic.sv
// read_write_logic: CPU bus read/write front end for the 8259-compatible PIC.
// Registers the raw bus strobes, qualifies reads, and turns each completed
// write into a one-cycle strobe plus a command-word class decode.
module read_write_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select,
  input  logic       read_flag,
  input  logic       write_flag,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic       read_enable,
  output logic       read_a0,
  output logic       write_enable,
  output logic [7:0] write_data,
  output logic       icw1_write,
  output logic       ocw2_write,
  output logic       ocw3_write,
  output logic       a0_high_write
);

  typedef enum logic {
    WR_IDLE,
    WR_ACTIVE
  } wr_state_t;

  wr_state_t  state;
  wr_state_t  state_next;

  logic       cs_q;
  logic       rd_q;
  logic       wr_q;
  logic       a0_q;
  logic [7:0] d_q;
  logic       write_armed;
  logic       write_a0;
  logic       latch_write;
  logic       finish_write;
  logic       read_cond;

  // A read is qualified only when selected, RD# low and no write is competing.
  assign read_cond = !cs_q && !rd_q && wr_q;

  // Sample the asynchronous bus pins; strobes come out of reset inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= 1'b1;
      rd_q <= 1'b1;
      wr_q <= 1'b1;
      a0_q <= 1'b0;
      d_q  <= 8'h00;
    end else begin
      cs_q <= chip_select;
      rd_q <= read_flag;
      wr_q <= write_flag;
      a0_q <= a0;
      d_q  <= data_in;
    end
  end

  // A write may only start once WR# has been seen high after reset, so a WR#
  // low pulse that straddles reset release never produces a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_armed <= 1'b0;
    end else if (write_flag) begin
      write_armed <= 1'b1;
    end
  end

  // Write tracking state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write tracking: start on selected WR# low, finish on WR# rise, abort on CS# rise.
  always_comb begin
    state_next   = state;
    latch_write  = 1'b0;
    finish_write = 1'b0;
    unique case (state)
      WR_IDLE: begin
        if (!cs_q && !wr_q && write_armed) begin
          state_next  = WR_ACTIVE;
          latch_write = 1'b1;
        end
      end
      WR_ACTIVE: begin
        if (cs_q) begin
          state_next = WR_IDLE;
        end else if (!wr_q) begin
          latch_write = 1'b1;
        end else begin
          state_next   = WR_IDLE;
          finish_write = 1'b1;
        end
      end
    endcase
  end

  // Track the bus data and A0 while WR# is low; the last value before the rise wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_data <= 8'h00;
      write_a0   <= 1'b0;
    end else if (latch_write) begin
      write_data <= d_q;
      write_a0   <= a0_q;
    end
  end

  // One-cycle write strobe with exactly one command-class pulse alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable  <= 1'b0;
      icw1_write    <= 1'b0;
      ocw2_write    <= 1'b0;
      ocw3_write    <= 1'b0;
      a0_high_write <= 1'b0;
    end else begin
      write_enable  <= finish_write;
      a0_high_write <= finish_write && write_a0;
      icw1_write    <= finish_write && !write_a0 && write_data[4];
      ocw2_write    <= finish_write && !write_a0 && !write_data[4] && !write_data[3];
      ocw3_write    <= finish_write && !write_a0 && !write_data[4] && write_data[3];
    end
  end

  // Registered read enable; read_a0 remembers A0 of the current or last read.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_enable <= 1'b0;
      read_a0     <= 1'b0;
    end else begin
      read_enable <= read_cond;
      if (read_cond) begin
        read_a0 <= a0_q;
      end
    end
  end

endmodule

// File: tb/tb_read_write_logic.sv
// Self-checking bench for read_write_logic: directed bus transactions followed
// by a random transaction mix, checked against per-cycle expectations that the
// transaction tasks derive from the bus timing rules.
module tb_read_write_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       chip_select;
  logic       read_flag;
  logic       write_flag;
  logic       a0;
  logic [7:0] data_in;
  logic       read_enable;
  logic       read_a0;
  logic       write_enable;
  logic [7:0] write_data;
  logic       icw1_write;
  logic       ocw2_write;
  logic       ocw3_write;
  logic       a0_high_write;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected outputs indexed by clock edge number.
  bit       exp_re   [1024];
  bit       exp_ra0  [1024];
  bit       exp_we   [1024];
  bit [7:0] exp_wd   [1024];
  bit [3:0] exp_kind [1024];
  bit [7:0] model_wd;

  // 100 MHz style free-running clock.
  always #5 clk = ~clk;

  read_write_logic dut (
    .clk           (clk),
    .reset         (reset),
    .chip_select   (chip_select),
    .read_flag     (read_flag),
    .write_flag    (write_flag),
    .a0            (a0),
    .data_in       (data_in),
    .read_enable   (read_enable),
    .read_a0       (read_a0),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .icw1_write    (icw1_write),
    .ocw2_write    (ocw2_write),
    .ocw3_write    (ocw3_write),
    .a0_high_write (a0_high_write)
  );

  // Command class as {icw1, ocw2, ocw3, a0_high} from A0 and the data byte.
  function automatic bit [3:0] decodeKind(input bit ad, input bit [7:0] d);
    if (ad)        return 4'b0001;
    else if (d[4]) return 4'b1000;
    else if (d[3]) return 4'b0010;
    else           return 4'b0100;
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("read_enable", {7'd0, read_enable}, {7'd0, exp_re[cyc]});
    checkValue("write_enable", {7'd0, write_enable}, {7'd0, exp_we[cyc]});
    checkValue("decode", {4'd0, icw1_write, ocw2_write, ocw3_write, a0_high_write}, {4'd0, exp_kind[cyc]});
    if (exp_we[cyc]) checkValue("write_data", write_data, exp_wd[cyc]);
    if (exp_re[cyc]) checkValue("read_a0", {7'd0, read_a0}, {7'd0, exp_ra0[cyc]});
  endtask

  // Drive one cycle of bus pins, clock it in, then check just after the edge.
  task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                               input logic ad, input logic [7:0] d, input logic rst);
    chip_select = cs;
    read_flag   = rd;
    write_flag  = wr;
    a0          = ad;
    data_in     = d;
    reset       = rst;
    @(posedge clk);
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic idleTick(input logic cs);
    applyStimulus(cs, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
  endtask

  // RD# low for len cycles: read_enable follows two edges later, one cycle per cycle.
  task automatic doRead(input int len);
    for (int i = 0; i < len; i++) begin
      bit ai;
      ai = 1'($urandom_range(0, 1));
      exp_re[cyc + 2]  = 1'b1;
      exp_ra0[cyc + 2] = ai;
      applyStimulus(1'b0, 1'b0, 1'b1, ai, 8'($urandom), 1'b0);
    end
    idleTick(1'b0);
  endtask

  // WR# low for len cycles (optionally with RD# low too); the final cycle's
  // A0/data is what gets committed, and the strobe lands two edges after it.
  task automatic doWrite(input int len, input bit ad, input bit [7:0] d, input bit rd_too);
    for (int i = 0; i < len; i++) begin
      logic       ai;
      logic [7:0] di;
      ai = (i == len - 1) ? ad : 1'($urandom_range(0, 1));
      di = (i == len - 1) ? d  : 8'($urandom);
      applyStimulus(1'b0, !rd_too, 1'b0, ai, di, 1'b0);
    end
    exp_we[cyc + 2]   = 1'b1;
    exp_wd[cyc + 2]   = d;
    exp_kind[cyc + 2] = decodeKind(ad, d);
    model_wd          = d;
    idleTick(1'b0);
  endtask

  initial begin
    chip_select = 1'b1;
    read_flag   = 1'b1;
    write_flag  = 1'b1;
    a0          = 1'b0;
    data_in     = 8'h00;
    reset       = 1'b1;
    model_wd    = 8'h00;

    // Reset state.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    checkValue("reset_write_data", write_data, 8'h00);
    checkValue("reset_read_a0", {7'd0, read_a0}, 8'h00);
    idleTick(1'b0);
    idleTick(1'b0);

    // Plain read, RD# low 3 cycles.
    doRead(3);

    // Two back-to-back one-cycle writes: ICW1 then an A0=1 word.
    doWrite(1, 1'b0, 8'h13, 1'b0);
    doWrite(1, 1'b1, 8'h20, 1'b0);

    // OCW2 and OCW3 decode.
    doWrite(2, 1'b0, 8'h20, 1'b0);
    doWrite(3, 1'b0, 8'h0B, 1'b0);

    // Deselected: strobes toggle, nothing happens and write_data holds.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
    idleTick(1'b1);
    idleTick(1'b0);
    idleTick(1'b0);
    checkValue("cs_high_write_data", write_data, model_wd);

    // RD# and WR# low together, then write / read / write.
    doWrite(2, 1'b0, 8'h13, 1'b1);
    doWrite(1, 1'b1, 8'($urandom), 1'b0);
    doRead(2);
    doWrite(2, 1'b0, 8'h0B, 1'b0);

    // Random transaction mix.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: doRead(int'($urandom_range(1, 4)));
        1: doWrite(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        2: doWrite(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        default: idleTick(1'($urandom_range(0, 1)));
      endcase
    end
    idleTick(1'b0);
    idleTick(1'b0);
    idleTick(1'b0);
    checkValue("idle_write_data", write_data, model_wd);

    // Reset while WR# is low, WR# rises one cycle after release: no strobe.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1);
    checkValue("midwrite_reset_write_data", write_data, 8'h00);
    checkValue("midwrite_reset_read_a0", {7'd0, read_a0}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) idleTick(1'b0);
    checkValue("post_reset_write_data", write_data, 8'h00);
    model_wd = 8'h00;

    // Normal operation resumes after reset.
    doWrite(2, 1'b1, 8'hA5, 1'b0);
    idleTick(1'b0);
    idleTick(1'b0);
    checkValue("final_write_data", write_data, model_wd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
